// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC register and instruction-fetch sequencer (optional counter: PC_FETCH_COUNT_EN)
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc_out,
  input  logic [31:0] pc_next_in,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic        squash_q, squash_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        req_q, req_d;

  // Next-state logic: sequencing, redirect handling and registered-output targets
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    tgt_d    = tgt_q;
    squash_d = squash_q;
    instr_d  = instr_q;
    case (state_q)
      S_IDLE: begin
        if (branch_taken) pc_d = branch_target;
        state_d = S_REQ;
      end
      S_REQ: begin
        if (imem_ack) begin
          if (squash_q || branch_taken) begin
            // Response belongs to the stale path: drop it and restart at the redirect
            pc_d     = branch_taken ? branch_target : tgt_q;
            squash_d = 1'b0;
            state_d  = S_IDLE;
          end else begin
            instr_d = imem_rdata;
            state_d = S_HOLD;
          end
        end else if (branch_taken) begin
          // Request is in flight with the old address; remember the newest target
          tgt_d    = branch_target;
          squash_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (branch_taken) begin
          pc_d    = branch_target;
          state_d = S_REQ;
        end else if (instr_ready) begin
          pc_d    = pc_next_in;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
    req_d   = (state_d == S_REQ);
    valid_d = (state_d == S_HOLD);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      tgt_q    <= 32'h0;
      squash_q <= 1'b0;
      instr_q  <= 32'h0;
      valid_q  <= 1'b0;
      req_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      tgt_q    <= tgt_d;
      squash_q <= squash_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      req_q    <= req_d;
    end
  end

  assign pc_out      = pc_q;
  assign imem_req    = req_q;
  assign instr_out   = instr_q;
  assign instr_valid = valid_q;

`ifdef PC_FETCH_COUNT_EN
  logic [31:0] count_q, count_d;
  logic        xfer;

  // A transfer is an accepted instruction that was not overridden by a redirect
  assign xfer    = (state_q == S_HOLD) && instr_ready && !branch_taken;
  assign count_d = count_q + {31'h0, xfer};

  // Accepted-instruction counter, wraps naturally at 2^32
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= 32'h0;
    else     count_q <= count_d;
  end

  assign fetch_count = count_q;
`else
  assign fetch_count = 32'h0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - randomized self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_out;
  logic [31:0] pc_next_in;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        imem_req;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] fetch_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: what the fetch engine has outstanding, at transaction level
  logic [31:0] m_pc;
  logic        m_req;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_cnt;
  logic        m_redir;
  logic [31:0] m_redir_pc;

  pc_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_out       (pc_out),
    .pc_next_in   (pc_next_in),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr_out    (instr_out),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .fetch_count  (fetch_count)
  );

  always #5 clk = ~clk;

  // Incrementer and memory contents (data word = 0xA0 + address)
  assign pc_next_in = pc_out + 32'd1;
  assign imem_rdata = 32'hA0 + pc_out;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_count();
`ifdef PC_FETCH_COUNT_EN
    return m_cnt;
`else
    return 32'h0;
`endif
  endfunction

  task automatic model_reset();
    m_pc = RST_PC; m_req = 0; m_valid = 0; m_instr = 0;
    m_cnt = 0; m_redir = 0; m_redir_pc = 0;
  endtask

  task automatic model_step(input logic br, input logic [31:0] tgt, input logic ack, input logic rdy);
    if (m_req) begin
      if (ack) begin
        m_req = 0;
        if (br || m_redir) begin
          m_pc    = br ? tgt : m_redir_pc;
          m_redir = 0;
        end else begin
          m_instr = 32'hA0 + m_pc;
          m_valid = 1;
        end
      end else if (br) begin
        m_redir    = 1;
        m_redir_pc = tgt;
      end
    end else if (m_valid) begin
      if (br) begin
        m_valid = 0; m_pc = tgt; m_req = 1;
      end else if (rdy) begin
        m_valid = 0; m_pc = m_pc + 32'd1; m_req = 1; m_cnt = m_cnt + 32'd1;
      end
    end else begin
      if (br) m_pc = tgt;
      m_req = 1;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},    pc_out, m_pc);
    check({tag, ".req"},   {31'h0, imem_req}, {31'h0, m_req});
    check({tag, ".valid"}, {31'h0, instr_valid}, {31'h0, m_valid});
    check({tag, ".instr"}, instr_out, m_instr);
    check({tag, ".count"}, fetch_count, exp_count());
  endtask

  // Inputs are driven just after a falling edge, results sampled at the next falling edge
  task automatic cycle(input logic br, input logic [31:0] tgt, input logic ack, input logic rdy);
    branch_taken  = br;
    branch_target = tgt;
    imem_ack      = ack;
    instr_ready   = rdy;
    @(posedge clk);
    model_step(br, tgt, ack, rdy);
    @(negedge clk);
    check_all("cyc");
  endtask

  logic [31:0] cnt_before;

  initial begin
    model_reset();
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst.pc",    pc_out, 32'h100);
    check("rst.req",   {31'h0, imem_req}, 32'h0);
    check("rst.valid", {31'h0, instr_valid}, 32'h0);
    check("rst.instr", instr_out, 32'h0);
    check("rst.count", fetch_count, 32'h0);
    rst = 1'b0;

    cycle(0, 0, 0, 1);
    check("first_req.pc",  pc_out, 32'h100);
    check("first_req.req", {31'h0, imem_req}, 32'h1);

    // Sequential fetches, ack on the third request cycle
    for (int k = 0; k < 3; k++) begin
      check("seq.addr", pc_out, 32'h100 + k);
      cycle(0, 0, 0, 1);
      cycle(0, 0, 0, 1);
      cycle(0, 0, 1, 1);
      check("seq.instr", instr_out, 32'h1A0 + k);
      cycle(0, 0, 0, 1);
    end
`ifdef PC_FETCH_COUNT_EN
    check("seq.count3", fetch_count, 32'd3);
`endif

    // Decode stall in hold
    cycle(0, 0, 1, 0);
    for (int k = 0; k < 5; k++) begin
      cycle(0, 0, 0, 0);
      check("stall.valid", {31'h0, instr_valid}, 32'h1);
      check("stall.noreq", {31'h0, imem_req}, 32'h0);
      check("stall.instr", instr_out, 32'h1A3);
    end
    cycle(0, 0, 0, 1);

    // Redirect while request is outstanding
    cycle(1, 32'h200, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 0);
    check("sq.novalid", {31'h0, instr_valid}, 32'h0);
    check("sq.idle",    {31'h0, imem_req}, 32'h0);
    cycle(0, 0, 0, 0);
    check("sq.req",     {31'h0, imem_req}, 32'h1);
    check("sq.pc",      pc_out, 32'h200);

    // Redirect in hold coincident with ready
    cycle(0, 0, 1, 0);
    cnt_before = fetch_count;
    cycle(1, 32'h300, 0, 1);
    check("hbr.pc",    pc_out, 32'h300);
    check("hbr.req",   {31'h0, imem_req}, 32'h1);
    check("hbr.count", fetch_count, cnt_before);

    // PC wrap via the incrementer
    cycle(0, 0, 1, 0);
    cycle(1, 32'hFFFF_FFFF, 0, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 1);
    check("wrap.pc", pc_out, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic        br;
      logic [31:0] tgt;
      br  = ($urandom_range(0, 7) == 0);
      tgt = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : $urandom;
      cycle(br, tgt, ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0));
    end

    // Reset asserted in the middle of a request; a late ack must be ignored
    for (int k = 0; k < 10 && !m_req; k++) cycle(0, 0, 0, 1);
    check("mid.inreq", {31'h0, imem_req}, 32'h1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("mid.req",   {31'h0, imem_req}, 32'h0);
    check("mid.pc",    pc_out, 32'h100);
    check("mid.valid", {31'h0, instr_valid}, 32'h0);
    imem_ack = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cycle(0, 0, 1, 1);
    check("late_ack.valid", {31'h0, instr_valid}, 32'h0);
    check("late_ack.req",   {31'h0, imem_req}, 32'h1);
    cycle(0, 0, 1, 1);
    check("late_ack.instr", instr_out, 32'h1A0);
    cycle(0, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
